// File: rtl/interleaved_fifo_pkg.sv
// Shared constants and helpers for the two-bank interleaved FIFO controller.
package interleaved_fifo_pkg;

    localparam int RAM_RD_LAT     = 2;
    localparam int PREFETCH_DEPTH = 3;

    // Even pointers live in bank 0, odd pointers in bank 1.
    function automatic logic bank_sel(input logic [31:0] ptr);
        return (ptr & 32'd1) != 32'd0;
    endfunction

endpackage

// File: rtl/interleaved_fifo_ctrl_ram.sv
// Single-port bank RAM: one read or write per cycle, registered address and data (2-cycle read).
module single_port_RAM #(
    parameter int  DATA_WIDTH = 8,
    parameter int  DEPTH      = 128,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  we,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         rd_addr_q, rd_addr_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    always_comb begin
        rd_addr_d = rd_addr_q;
        if (en && !we) begin
            rd_addr_d = addr;
        end
        rdata_d = mem[rd_addr_q];
    end

    // NOTE: the storage array has no reset; contents survive rst_n and only the pipeline is cleared.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_q <= '0;
            rdata_q   <= '0;
        end else begin
            rd_addr_q <= rd_addr_d;
            rdata_q   <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/interleaved_fifo_ctrl.sv
// FIFO over two interleaved single-port banks with a 3-entry prefetch buffer feeding registered outputs.
module interleaved_fifo_ctrl
    import interleaved_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 256
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DATA_WIDTH-1:0]       in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(FIFO_DEPTH):0] level
);

    localparam int LB         = $clog2(FIFO_DEPTH);
    localparam int PW         = LB + 1;
    localparam int BANK_WORDS = FIFO_DEPTH / 2;
    localparam int OCC_W      = $clog2(PREFETCH_DEPTH + 1);
    localparam int CW         = OCC_W + 1;

    logic [PW-1:0]         wr_q, wr_d, rd_q, rd_d, level_q, level_d;
    logic                  init_q, init_d;
    logic [RAM_RD_LAT-1:0] vld_q, vld_d, bnk_q, bnk_d;
    logic [DATA_WIDTH-1:0] pf_q [PREFETCH_DEPTH];
    logic [DATA_WIDTH-1:0] pf_d [PREFETCH_DEPTH];
    logic [OCC_W-1:0]      occ_q, occ_d;

    logic                  rd_bank, wr_bank, pop, push, issue, conflict, ready;
    logic [CW-1:0]         in_flight, held;
    logic [1:0]            bank_en, bank_we;
    logic [LB-2:0]         bank_addr  [2];
    logic [DATA_WIDTH-1:0] bank_rdata [2];
    logic [DATA_WIDTH-1:0] ret_data;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        rd_bank   = bank_sel(32'(rd_q));
        wr_bank   = bank_sel(32'(wr_q));
        pop       = (occ_q != '0) && out_ready;
        in_flight = '0;
        for (int i = 0; i < RAM_RD_LAT; i++) begin
            in_flight = in_flight + CW'(vld_q[i]);
        end
        // A slot freed by this cycle's pop can be refilled by this cycle's issue.
        held     = CW'(occ_q) + in_flight;
        issue    = (rd_q != wr_q) && ((held - CW'(pop)) < CW'(PREFETCH_DEPTH));
        conflict = issue && (rd_bank == wr_bank);
        ready    = init_q && (level_q < PW'(FIFO_DEPTH)) && !conflict;
        push     = in_valid && ready;
    end

    always_comb begin
        bank_en = '0;
        bank_we = '0;
        for (int b = 0; b < 2; b++) begin
            bank_en[b]   = (issue && rd_bank == 1'(b)) || (push && wr_bank == 1'(b));
            bank_we[b]   = push && (wr_bank == 1'(b));
            bank_addr[b] = (issue && rd_bank == 1'(b)) ? rd_q[LB-1:1] : wr_q[LB-1:1];
        end
    end

    always_comb begin
        wr_d    = push  ? wr_q + PW'(1) : wr_q;
        rd_d    = issue ? rd_q + PW'(1) : rd_q;
        level_d = level_q + PW'(push) - PW'(pop);
        init_d  = 1'b1;
        vld_d   = {vld_q[RAM_RD_LAT-2:0], issue};
        bnk_d   = {bnk_q[RAM_RD_LAT-2:0], rd_bank};
    end

    // NOTE: blocking assignments here build the next buffer image step by step: shift on pop, then append.
    always_comb begin
        ret_data = bank_rdata[bnk_q[RAM_RD_LAT-1]];
        pf_d     = pf_q;
        occ_d    = occ_q;
        if (pop) begin
            for (int i = 0; i < PREFETCH_DEPTH - 1; i++) begin
                pf_d[i] = pf_q[i+1];
            end
            occ_d = occ_q - OCC_W'(1);
        end
        if (vld_q[RAM_RD_LAT-1]) begin
            pf_d[occ_d] = ret_data;
            occ_d       = occ_d + OCC_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            init_q  <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            init_q  <= init_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            bnk_q <= '0;
        end else begin
            vld_q <= vld_d;
            bnk_q <= bnk_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= '0;
            for (int i = 0; i < PREFETCH_DEPTH; i++) begin
                pf_q[i] <= '0;
            end
        end else begin
            occ_q <= occ_d;
            pf_q  <= pf_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        single_port_RAM #(DATA_WIDTH, BANK_WORDS) u_ram (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (bank_en[b]),
            .we    (bank_we[b]),
            .addr  (bank_addr[b]),
            .wdata (in_data),
            .rdata (bank_rdata[b])
        );
    end

    assign in_ready  = ready;
    assign out_valid = (occ_q != '0);
    assign out_data  = pf_q[0];
    assign level     = level_q;

endmodule

// File: tb/tb_interleaved_fifo_ctrl.sv
// Randomized and directed checks of interleaved_fifo_ctrl (depth 8) against a queue-based FIFO model.
module tb_interleaved_fifo_ctrl;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] level;

    int errors = 0;
    int checks = 0;

    logic [7:0] model [$];
    logic       ov_s, rdy_s, push_s, pop_s;
    logic [7:0] od_s;
    logic [3:0] lvl_s;

    always #5 clk = ~clk;

    interleaved_fifo_ctrl #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level)
    );

    // One cycle: drive at negedge, sample and check, then apply the handshake to the model at posedge.
    task automatic step(input logic iv, input logic [7:0] d, input logic ordy);
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #1;
        ov_s   = out_valid;
        od_s   = out_data;
        rdy_s  = in_ready;
        lvl_s  = level;
        push_s = iv && rdy_s;
        pop_s  = ov_s && ordy;
        checks++;
        if (lvl_s !== 4'(model.size())) begin
            errors++;
            $display("FAIL level: got %0d expected %0d", lvl_s, model.size());
        end
        checks++;
        if (lvl_s > 4'(DEPTH)) begin
            errors++;
            $display("FAIL level_bound: got %0d limit %0d", lvl_s, DEPTH);
        end
        checks++;
        if (model.size() == DEPTH && rdy_s !== 1'b0) begin
            errors++;
            $display("FAIL full_ready: got in_ready=%b expected 0 when full", rdy_s);
        end
        checks++;
        if (model.size() == 0 && ov_s !== 1'b0) begin
            errors++;
            $display("FAIL stale_valid: got out_valid=%b expected 0 when empty", ov_s);
        end
        if (pop_s) begin
            checks++;
            if (model.size() == 0) begin
                errors++;
                $display("FAIL pop_empty: got pop of %0h expected none", od_s);
            end else if (od_s !== model[0]) begin
                errors++;
                $display("FAIL data: got %0h expected %0h", od_s, model[0]);
            end
        end
        @(posedge clk);
        if (pop_s && model.size() > 0) void'(model.pop_front());
        if (push_s) model.push_back(d);
    endtask

    task automatic push_words(input int n, input logic [7:0] base, input logic ordy);
        int cnt = 0;
        for (int i = 0; i < 200 && cnt < n; i++) begin
            step(1'b1, base + 8'(cnt), ordy);
            if (push_s) cnt++;
        end
        checks++;
        if (cnt != n) begin
            errors++;
            $display("FAIL push_timeout: got %0d pushes expected %0d", cnt, n);
        end
    endtask

    task automatic drain();
        int i = 0;
        while (model.size() != 0 && i < 200) begin
            step(1'b0, 8'h00, 1'b1);
            i++;
        end
        checks++;
        if (model.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d words left expected 0", model.size());
        end
        repeat (3) step(1'b0, 8'h00, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || level !== 4'd0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s: got valid=%b data=%0h level=%0d ready=%b expected 0/0/0/0",
                     tag, out_valid, out_data, level, in_ready);
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_state");
        release_reset();
    endtask

    task automatic test_single_word();
        step(1'b1, 8'hA5, 1'b0);
        checks++;
        if (rdy_s !== 1'b1) begin
            errors++;
            $display("FAIL single_ready: got %b expected 1", rdy_s);
        end
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 8'h00, 1'b0);
            checks++;
            if (ov_s !== 1'b0) begin
                errors++;
                $display("FAIL early_valid: got 1 expected 0 after edge %0d", k);
            end
        end
        step(1'b0, 8'h00, 1'b0);
        checks++;
        if (ov_s !== 1'b1 || od_s !== 8'hA5 || lvl_s !== 4'd1) begin
            errors++;
            $display("FAIL single_latency: got valid=%b data=%0h level=%0d expected 1/a5/1", ov_s, od_s, lvl_s);
        end
        drain();
    endtask

    task automatic test_full();
        push_words(DEPTH, 8'h00, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 8'h08, 1'b0);
            checks++;
            if (rdy_s !== 1'b0 || lvl_s !== 4'(DEPTH)) begin
                errors++;
                $display("FAIL full_offer: got ready=%b level=%0d expected 0/%0d", rdy_s, lvl_s, DEPTH);
            end
        end
        checks++;
        if (model.size() != DEPTH || model[0] !== 8'h00 || model[DEPTH-1] !== 8'h07) begin
            errors++;
            $display("FAIL full_contents: got %0d words expected 8 words 0..7", model.size());
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int wr_i = 0;
        int pops = 0;
        logic [3:0] lvl_ref = '0;
        for (int c = 0; c < 800 && !(wr_i == 256 && model.size() == 0); c++) begin
            step(wr_i < 256, 8'(wr_i), 1'b1);
            if (push_s) wr_i++;
            if (pop_s) pops++;
            if (c == 8) lvl_ref = lvl_s;
            if (c > 8 && c < 200) begin
                checks++;
                if (!(push_s && pop_s) || lvl_s !== lvl_ref) begin
                    errors++;
                    $display("FAIL throughput: got push=%b pop=%b level=%0d expected 1/1/%0d at cycle %0d",
                             push_s, pop_s, lvl_s, lvl_ref, c);
                end
            end
        end
        checks++;
        if (pops != 256 || wr_i != 256) begin
            errors++;
            $display("FAIL stream_count: got %0d pushes %0d pops expected 256/256", wr_i, pops);
        end
        drain();
    endtask

    // Three words prefetched: the next read targets word 3, the pending write is word 5 -> same bank.
    task automatic test_conflict();
        push_words(5, 8'h30, 1'b0);
        repeat (2) step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'hC5, 1'b1);
        checks++;
        if (rdy_s !== 1'b0 || pop_s !== 1'b1) begin
            errors++;
            $display("FAIL conflict_cycle: got ready=%b pop=%b expected 0/1", rdy_s, pop_s);
        end
        step(1'b1, 8'hC5, 1'b1);
        checks++;
        if (rdy_s !== 1'b1) begin
            errors++;
            $display("FAIL conflict_next: got ready=%b expected 1", rdy_s);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        push_words(5, 8'h40, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        model.delete();
        release_reset();
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 8'h00, 1'b1);
            if (ov_s) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL stale_after_reset: got %0d valid cycles expected 0", seen);
        end
        push_words(1, 8'h77, 1'b1);
        drain();
    endtask

    task automatic test_random();
        int pushed = 0;
        for (int c = 0; c < 4000 && pushed < 320; c++) begin
            step(($urandom % 4) != 0 && pushed < 320, 8'($urandom), 1'($urandom % 2));
            if (push_s) pushed++;
        end
        checks++;
        if (pushed != 320) begin
            errors++;
            $display("FAIL random_timeout: got %0d pushes expected 320", pushed);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_full();
        test_back_to_back();
        test_conflict();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected completion within 500us");
        $fatal(1, "watchdog expired");
    end

endmodule
